// File: rtl/parking_gate_controller_if.sv
// Handshake, gate and occupancy signals shared between the car-park gate
// controller (slave) and whatever drives the entry/exit requests (master).
interface parking_gate_controller_if;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic       entry_ack;
    logic       entry_reject;
    logic [2:0] entry_slot;
    logic       exit_ack;
    logic       exit_err;
    logic       entry_gate;
    logic       exit_gate;
    logic [7:0] free_map;
    logic [3:0] parked;
    logic [3:0] empty;
    logic       busy;

    modport master (
        output entry_req, exit_req, exit_slot,
        input  entry_ack, entry_reject, entry_slot, exit_ack, exit_err,
        input  entry_gate, exit_gate, free_map, parked, empty, busy
    );

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output entry_ack, entry_reject, entry_slot, exit_ack, exit_err,
        output entry_gate, exit_gate, free_map, parked, empty, busy
    );
endinterface

// File: rtl/parking_gate_controller.sv
// Round-robin entry/exit gate sequencer for an 8-slot car park; owns the
// occupancy map (1 = empty) and keeps parked/empty counts in step with it.
module parking_gate_controller #(
    parameter int         GATE_CYCLES = 4,
    parameter logic [7:0] INIT_FREE   = 8'hFF
) (
    input logic                       clk,
    input logic                       reset,
    parking_gate_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ENT_OPEN,
        EXT_OPEN,
        HOLD
    } state_t;

    localparam logic [7:0] GATE_LOAD  = 8'(GATE_CYCLES - 1);
    localparam logic [3:0] INIT_EMPTY = 4'($countones(INIT_FREE));

    state_t     state, state_next;
    logic       token_exit, token_exit_next;
    logic [7:0] gate_cnt, gate_cnt_next;
    logic       entry_ack_next, entry_reject_next, exit_ack_next, exit_err_next;
    logic       entry_gate_next, exit_gate_next;
    logic [2:0] entry_slot_next;
    logic [7:0] free_map_next;
    logic [3:0] parked_next, empty_next;
    logic [2:0] lowest_free;
    logic       serve_entry, serve_exit;

    // Priority encoder: lowest index whose map bit is 1 (only used when map != 0)
    always_comb begin
        lowest_free = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.free_map[i]) lowest_free = 3'(i);
        end
    end

    // Both requests pending: the token side wins; otherwise whoever is asking
    assign serve_entry = bus.entry_req && (!bus.exit_req || !token_exit);
    assign serve_exit  = bus.exit_req && !serve_entry;

    always_comb begin
        state_next        = state;
        token_exit_next   = token_exit;
        gate_cnt_next     = gate_cnt;
        entry_ack_next    = 1'b0;
        entry_reject_next = 1'b0;
        exit_ack_next     = 1'b0;
        exit_err_next     = 1'b0;
        entry_gate_next   = bus.entry_gate;
        exit_gate_next    = bus.exit_gate;
        entry_slot_next   = bus.entry_slot;
        free_map_next     = bus.free_map;
        parked_next       = bus.parked;
        empty_next        = bus.empty;

        case (state)
            IDLE: begin
                if (serve_entry) begin
                    entry_ack_next  = 1'b1;
                    token_exit_next = 1'b1;
                    if (bus.free_map != 8'h00) begin
                        entry_slot_next              = lowest_free;
                        free_map_next[lowest_free]   = 1'b0;
                        parked_next                  = bus.parked + 4'd1;
                        empty_next                   = bus.empty - 4'd1;
                        entry_gate_next              = 1'b1;
                        gate_cnt_next                = GATE_LOAD;
                        state_next                   = ENT_OPEN;
                    end else begin
                        entry_reject_next = 1'b1;
                        state_next        = HOLD;
                    end
                end else if (serve_exit) begin
                    exit_ack_next   = 1'b1;
                    token_exit_next = 1'b0;
                    if (!bus.free_map[bus.exit_slot]) begin
                        free_map_next[bus.exit_slot] = 1'b1;
                        parked_next                  = bus.parked - 4'd1;
                        empty_next                   = bus.empty + 4'd1;
                        exit_gate_next               = 1'b1;
                        gate_cnt_next                = GATE_LOAD;
                        state_next                   = EXT_OPEN;
                    end else begin
                        exit_err_next = 1'b1;
                        state_next    = HOLD;
                    end
                end
            end
            ENT_OPEN: begin
                if (gate_cnt == 8'd0) begin
                    entry_gate_next = 1'b0;
                    state_next      = IDLE;
                end else begin
                    gate_cnt_next = gate_cnt - 8'd1;
                end
            end
            EXT_OPEN: begin
                if (gate_cnt == 8'd0) begin
                    exit_gate_next = 1'b0;
                    state_next     = IDLE;
                end else begin
                    gate_cnt_next = gate_cnt - 8'd1;
                end
            end
            HOLD: begin
                // One dead cycle so a requester that just saw its ack can drop req
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            token_exit       <= 1'b0;
            gate_cnt         <= 8'd0;
            bus.entry_ack    <= 1'b0;
            bus.entry_reject <= 1'b0;
            bus.exit_ack     <= 1'b0;
            bus.exit_err     <= 1'b0;
            bus.entry_gate   <= 1'b0;
            bus.exit_gate    <= 1'b0;
            bus.entry_slot   <= 3'd0;
            bus.free_map     <= INIT_FREE;
            bus.parked       <= 4'd8 - INIT_EMPTY;
            bus.empty        <= INIT_EMPTY;
            bus.busy         <= 1'b0;
        end else begin
            state            <= state_next;
            token_exit       <= token_exit_next;
            gate_cnt         <= gate_cnt_next;
            bus.entry_ack    <= entry_ack_next;
            bus.entry_reject <= entry_reject_next;
            bus.exit_ack     <= exit_ack_next;
            bus.exit_err     <= exit_err_next;
            bus.entry_gate   <= entry_gate_next;
            bus.exit_gate    <= exit_gate_next;
            bus.entry_slot   <= entry_slot_next;
            bus.free_map     <= free_map_next;
            bus.parked       <= parked_next;
            bus.empty        <= empty_next;
            bus.busy         <= (state_next != IDLE);
        end
    end

endmodule
